// File: rtl/dma_copy_engine.sv
// dma_copy_engine: single-channel DMA copy engine driving the arbiter's DMA port.
// Copies len 64-bit words from src_addr to dst_addr, one read then one write per
// word, with at most one memory transaction outstanding.
// Optional feature macro: DMA_FILL_EN adds fill / fill_pattern ports so the engine
// can write a constant pattern to len destination words without reading.
module dma_copy_engine #(
  parameter int unsigned STRIDE = 8,
  parameter int unsigned LEN_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      src_addr,
  input  logic [63:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
`ifdef DMA_FILL_EN
  input  logic             fill,
  input  logic [63:0]      fill_pattern,
`endif
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] words_done,
  output logic             req_dma,
  output logic             we_dma,
  output logic [63:0]      addr_dma,
  output logic [63:0]      wdata_dma,
  input  logic             gnt_dma,
  input  logic             valid_dma,
  input  logic [63:0]      rdata_dma
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    FIN     = 3'd4
  } state_t;

  // Control state (reset)
  state_t           state_q, state_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic             abort_pend_q, abort_pend_d;
  logic             aborted_q, aborted_d;

  // Datapath state (no reset: only observed while busy)
  logic [63:0]      src_q, src_d;
  logic [63:0]      dst_q, dst_d;
  logic [63:0]      data_q, data_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic             abort_eff;
  logic [LEN_W-1:0] words_inc;
  logic             fill_start;
  logic             fill_mode;

`ifdef DMA_FILL_EN
  logic             fill_q, fill_d;
  assign fill_start = fill;
  assign fill_mode  = fill_q;
`else
  assign fill_start = 1'b0;
  assign fill_mode  = 1'b0;
`endif

  // Control registers: state, progress counter, abort bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      words_q      <= '0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
`ifdef DMA_FILL_EN
      fill_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      words_q      <= words_d;
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
`ifdef DMA_FILL_EN
      fill_q       <= fill_d;
`endif
    end
  end

  // Datapath registers: addresses, captured word, length
  always_ff @(posedge clk) begin
    src_q  <= src_d;
    dst_q  <= dst_d;
    data_q <= data_d;
    len_q  <= len_d;
  end

  // Next-state logic for the transfer sequencer
  always_comb begin
    state_d      = state_q;
    words_d      = words_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;
    src_d        = src_q;
    dst_d        = dst_q;
    data_d       = data_q;
    len_d        = len_q;
`ifdef DMA_FILL_EN
    fill_d       = fill_q;
`endif
    // An abort arriving this cycle counts immediately, not only once it is sticky.
    abort_eff    = abort | abort_pend_q;
    words_inc    = words_q + LEN_W'(1);

    if ((state_q != IDLE) && abort) begin
      abort_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        abort_pend_d = 1'b0;
        aborted_d    = 1'b0;
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          words_d = '0;
`ifdef DMA_FILL_EN
          fill_d  = fill;
          data_d  = fill_pattern;
`endif
          if (len == '0)      state_d = FIN;
          else if (fill_start) state_d = WR_REQ;
          else                 state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        // Once granted the read must be allowed to return, so abort only wins
        // while the request is still ungranted.
        if (gnt_dma) begin
          state_d = RD_WAIT;
        end else if (abort_eff) begin
          state_d   = FIN;
          aborted_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (valid_dma) begin
          data_d = rdata_dma;
          if (abort_eff) begin
            state_d   = FIN;
            aborted_d = 1'b1;
          end else begin
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        if (gnt_dma) begin
          src_d   = src_q + 64'(STRIDE);
          dst_d   = dst_q + 64'(STRIDE);
          words_d = words_inc;
          // Completing the last word takes precedence over a simultaneous abort.
          if (words_inc == len_q) begin
            state_d = FIN;
          end else if (abort_eff) begin
            state_d   = FIN;
            aborted_d = 1'b1;
          end else if (fill_mode) begin
            state_d = WR_REQ;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode; req drops combinationally in the grant cycle
  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == FIN);
    aborted    = (state_q == FIN) && aborted_q;
    words_done = words_q;
    req_dma    = 1'b0;
    we_dma     = 1'b0;
    addr_dma   = '0;
    wdata_dma  = '0;
    case (state_q)
      RD_REQ: begin
        req_dma  = ~gnt_dma;
        addr_dma = src_q;
      end
      WR_REQ: begin
        req_dma   = ~gnt_dma;
        we_dma    = 1'b1;
        addr_dma  = dst_q;
        wdata_dma = data_q;
      end
      default: begin
        req_dma = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed testbench for dma_copy_engine with a behavioural arbiter/memory that
// grants after a programmable stall and returns read data one cycle after grant.
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] src_addr = '0;
  logic [63:0] dst_addr = '0;
  logic [31:0] len = '0;
  logic        abort = 1'b0;
`ifdef DMA_FILL_EN
  logic        fill = 1'b0;
  logic [63:0] fill_pattern = '0;
`endif
  logic        busy, done, aborted;
  logic [31:0] words_done;
  logic        req_dma, we_dma;
  logic [63:0] addr_dma, wdata_dma;
  logic        gnt_dma = 1'b0;
  logic        valid_dma = 1'b0;
  logic [63:0] rdata_dma = '0;

  int n_checks = 0;
  int n_fail = 0;

  // Memory model state
  int          gnt_delay = 0;
  int          stall_cnt = 0;
  logic        rd_pend = 1'b0;
  logic [63:0] rd_addr = '0;
  logic        req_seen = 1'b0;
  int          n_valid = 0;
  logic        log_we   [64];
  logic [63:0] log_addr [64];
  logic [63:0] log_data [64];
  int          log_n = 0;

  dma_copy_engine #(.STRIDE(8), .LEN_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .abort(abort),
`ifdef DMA_FILL_EN
    .fill(fill), .fill_pattern(fill_pattern),
`endif
    .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
    .req_dma(req_dma), .we_dma(we_dma), .addr_dma(addr_dma), .wdata_dma(wdata_dma),
    .gnt_dma(gnt_dma), .valid_dma(valid_dma), .rdata_dma(rdata_dma)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
  endfunction

  // Arbiter + 1-cycle memory: acts just after each falling edge
  always begin
    @(negedge clk);
    gnt_dma   = 1'b0;
    valid_dma = 1'b0;
    #1;
    if (rst) begin
      rd_pend   = 1'b0;
      stall_cnt = 0;
    end else begin
      if (rd_pend) begin
        valid_dma = 1'b1;
        rdata_dma = mem_word(rd_addr);
        rd_pend   = 1'b0;
        n_valid++;
      end
      if (req_dma) begin
        req_seen = 1'b1;
        if (stall_cnt < gnt_delay) begin
          stall_cnt++;
        end else begin
          stall_cnt = 0;
          gnt_dma   = 1'b1;
          if (log_n < 64) begin
            log_we[log_n]   = we_dma;
            log_addr[log_n] = addr_dma;
            log_data[log_n] = wdata_dma;
          end
          log_n++;
          if (!we_dma) begin
            rd_pend = 1'b1;
            rd_addr = addr_dma;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Issue a one-cycle start; returns at posedge+1 of the cycle after acceptance
  task automatic kick(input logic [63:0] s, input logic [63:0] d, input logic [31:0] l,
                      input logic f, input logic [63:0] pat);
    start = 1'b1; src_addr = s; dst_addr = d; len = l;
`ifdef DMA_FILL_EN
    fill = f; fill_pattern = pat;
`else
    if (f) $display("note: fill requested in a copy-only build");
    if (pat != 64'h0) $display("note: pattern ignored in a copy-only build");
`endif
    @(posedge clk); #1;
    start = 1'b0;
`ifdef DMA_FILL_EN
    fill = 1'b0;
`endif
  endtask

  task automatic run_until_idle(input int max, output int dones, output logic ab,
                                output logic [31:0] wd, output logic to);
    dones = 0; ab = 1'b0; wd = '0; to = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (done) begin dones++; ab = aborted; wd = words_done; end
      if (!busy) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_log();
    log_n = 0; req_seen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, aborted, req_dma, we_dma} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, aborted, req_dma, we_dma});
    end
    n_checks++;
    if ({words_done, addr_dma, wdata_dma} !== 160'h0) begin
      n_fail++; $display("FAIL reset_data: got wd=%h addr=%h wdata=%h expected 0", words_done, addr_dma, wdata_dma);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_copy();
    int dones; logic ab; logic [31:0] wd; logic to;
    clear_log();
    kick(64'h1000, 64'h2000, 3, 1'b0, 64'h0);
    n_checks++;
    if ({busy, req_dma} !== 2'b11) begin
      n_fail++; $display("FAIL copy_first_req: got busy,req=%b expected 11", {busy, req_dma});
    end
    run_until_idle(100, dones, ab, wd, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL copy_timeout: got %b expected 0", to); end
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL copy_done_pulses: got %0d expected 1", dones); end
    n_checks++;
    if (ab !== 1'b0) begin n_fail++; $display("FAIL copy_aborted: got %b expected 0", ab); end
    n_checks++;
    if (wd !== 32'd3) begin n_fail++; $display("FAIL copy_words: got %0d expected 3", wd); end
    n_checks++;
    if (log_n != 6) begin n_fail++; $display("FAIL copy_txn_count: got %0d expected 6", log_n); end
    for (int i = 0; i < 6 && i < log_n; i++) begin
      logic [63:0] ea;
      ea = ((i % 2) == 0) ? 64'h1000 + 64'(8 * (i / 2)) : 64'h2000 + 64'(8 * (i / 2));
      n_checks++;
      if ({log_we[i], log_addr[i]} !== {1'(i % 2), ea}) begin
        n_fail++; $display("FAIL copy_txn%0d: got we=%b addr=%h expected we=%0d addr=%h", i, log_we[i], log_addr[i], i % 2, ea);
      end
      if ((i % 2) == 1) begin
        n_checks++;
        if (log_data[i] !== mem_word(64'h1000 + 64'(8 * (i / 2)))) begin
          n_fail++; $display("FAIL copy_wdata%0d: got %h expected %h", i, log_data[i], mem_word(64'h1000 + 64'(8 * (i / 2))));
        end
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, words_done} !== {2'b00, 32'd3}) begin
      n_fail++; $display("FAIL copy_hold: got busy=%b done=%b wd=%0d expected 0 0 3", busy, done, words_done);
    end
  endtask

  task automatic test_len0();
    int dones; logic ab; logic [31:0] wd; logic to;
    clear_log();
    kick(64'h1000, 64'h2000, 0, 1'b0, 64'h0);
    n_checks++;
    if ({done, busy, words_done} !== {2'b11, 32'd0}) begin
      n_fail++; $display("FAIL len0_done: got done=%b busy=%b wd=%0d expected 1 1 0", done, busy, words_done);
    end
    run_until_idle(10, dones, ab, wd, to);
    n_checks++;
    if ({to, dones[3:0], ab} !== {1'b0, 4'd1, 1'b0}) begin
      n_fail++; $display("FAIL len0_end: got to=%b dones=%0d ab=%b expected 0 1 0", to, dones, ab);
    end
    n_checks++;
    if ({req_seen, log_n[7:0]} !== 9'd0) begin
      n_fail++; $display("FAIL len0_traffic: got req_seen=%b txns=%0d expected 0 0", req_seen, log_n);
    end
  endtask

  task automatic test_gnt_stall();
    int dones; logic ab; logic [31:0] wd; logic to;
    clear_log();
    gnt_delay = 10;
    kick(64'h3000, 64'h4000, 1, 1'b0, 64'h0);
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if ({req_dma, we_dma, addr_dma} !== {1'b1, 1'b0, 64'h3000}) begin
        n_fail++; $display("FAIL stall_hold%0d: got req=%b we=%b addr=%h expected 1 0 3000", k, req_dma, we_dma, addr_dma);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (log_n != 0) begin n_fail++; $display("FAIL stall_early_gnt: got %0d txns expected 0", log_n); end
    run_until_idle(100, dones, ab, wd, to);
    gnt_delay = 0;
    n_checks++;
    if ({to, dones[3:0], wd} !== {1'b0, 4'd1, 32'd1}) begin
      n_fail++; $display("FAIL stall_end: got to=%b dones=%0d wd=%0d expected 0 1 1", to, dones, wd);
    end
    n_checks++;
    if (log_n != 2) begin
      n_fail++; $display("FAIL stall_txn_count: got %0d expected 2", log_n);
    end else begin
      n_checks++;
      if ({log_we[0], log_addr[0], log_we[1], log_addr[1], log_data[1]} !==
          {1'b0, 64'h3000, 1'b1, 64'h4000, mem_word(64'h3000)}) begin
        n_fail++; $display("FAIL stall_txns: got rd %b/%h wr %b/%h/%h expected 0/3000 1/4000/%h",
                           log_we[0], log_addr[0], log_we[1], log_addr[1], log_data[1], mem_word(64'h3000));
      end
    end
  endtask

  task automatic test_abort_rd_wait();
    int dones; logic ab; logic [31:0] wd; logic to; int v0;
    clear_log();
    v0 = n_valid;
    kick(64'h5000, 64'h6000, 5, 1'b0, 64'h0);
    for (int i = 0; i < 50 && log_n < 3; i++) begin @(posedge clk); #1; end
    n_checks++;
    if ({busy, req_dma, log_n[7:0]} !== {1'b1, 1'b0, 8'd3}) begin
      n_fail++; $display("FAIL abort_reach_rdwait: got busy=%b req=%b txns=%0d expected 1 0 3", busy, req_dma, log_n);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if ({done, aborted} !== 2'b11) begin
      n_fail++; $display("FAIL abort_done: got done=%b aborted=%b expected 1 1", done, aborted);
    end
    run_until_idle(20, dones, ab, wd, to);
    n_checks++;
    if ({to, dones[3:0], ab, wd} !== {1'b0, 4'd1, 1'b1, 32'd1}) begin
      n_fail++; $display("FAIL abort_end: got to=%b dones=%0d ab=%b wd=%0d expected 0 1 1 1", to, dones, ab, wd);
    end
    n_checks++;
    if ({log_n[7:0], 8'(n_valid - v0)} !== {8'd3, 8'd2}) begin
      n_fail++; $display("FAIL abort_traffic: got txns=%0d valids=%0d expected 3 2", log_n, n_valid - v0);
    end
  endtask

  task automatic test_abort_last_write();
    int dones; logic ab; logic [31:0] wd; logic to;
    clear_log();
    kick(64'hA000, 64'hB000, 1, 1'b0, 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if ({req_dma, we_dma} !== 2'b11) begin
      n_fail++; $display("FAIL abort_last_wrreq: got req,we=%b expected 11", {req_dma, we_dma});
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    run_until_idle(20, dones, ab, wd, to);
    n_checks++;
    if ({to, dones[3:0], ab, wd, log_n[7:0]} !== {1'b0, 4'd1, 1'b0, 32'd1, 8'd2}) begin
      n_fail++; $display("FAIL abort_last: got to=%b dones=%0d ab=%b wd=%0d txns=%0d expected 0 1 0 1 2", to, dones, ab, wd, log_n);
    end
  endtask

  task automatic test_rst_mid();
    int dones; logic ab; logic [31:0] wd; logic to;
    clear_log();
    kick(64'hC000, 64'hD000, 2, 1'b0, 64'h0);
    for (int i = 0; i < 50 && !(we_dma && log_n == 3); i++) begin @(posedge clk); #1; end
    n_checks++;
    if ({we_dma, words_done} !== {1'b1, 32'd1}) begin
      n_fail++; $display("FAIL rst_reach_wrreq: got we=%b wd=%0d expected 1 1", we_dma, words_done);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, aborted, req_dma, we_dma, words_done, addr_dma, wdata_dma} !== 165'h0) begin
      n_fail++; $display("FAIL rst_async: got busy=%b req=%b we=%b wd=%0d addr=%h wdata=%h expected all 0",
                         busy, req_dma, we_dma, words_done, addr_dma, wdata_dma);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_log();
    kick(64'h7000, 64'h8000, 1, 1'b0, 64'h0);
    run_until_idle(50, dones, ab, wd, to);
    n_checks++;
    if ({to, dones[3:0], ab, wd} !== {1'b0, 4'd1, 1'b0, 32'd1}) begin
      n_fail++; $display("FAIL rst_restart_end: got to=%b dones=%0d ab=%b wd=%0d expected 0 1 0 1", to, dones, ab, wd);
    end
    n_checks++;
    if ({log_n[7:0], log_addr[0], log_addr[1], log_data[1]} !== {8'd2, 64'h7000, 64'h8000, mem_word(64'h7000)}) begin
      n_fail++; $display("FAIL rst_restart_txns: got n=%0d rd=%h wr=%h data=%h expected 2 7000 8000 %h",
                         log_n, log_addr[0], log_addr[1], log_data[1], mem_word(64'h7000));
    end
  endtask

`ifdef DMA_FILL_EN
  task automatic test_fill();
    int dones; logic ab; logic [31:0] wd; logic to;
    clear_log();
    kick(64'h1234, 64'h9000, 4, 1'b1, 64'hDEADBEEF_CAFEF00D);
    run_until_idle(100, dones, ab, wd, to);
    n_checks++;
    if ({to, dones[3:0], ab, wd, log_n[7:0]} !== {1'b0, 4'd1, 1'b0, 32'd4, 8'd4}) begin
      n_fail++; $display("FAIL fill_end: got to=%b dones=%0d ab=%b wd=%0d txns=%0d expected 0 1 0 4 4", to, dones, ab, wd, log_n);
    end
    for (int i = 0; i < 4 && i < log_n; i++) begin
      n_checks++;
      if ({log_we[i], log_addr[i], log_data[i]} !== {1'b1, 64'h9000 + 64'(8 * i), 64'hDEADBEEF_CAFEF00D}) begin
        n_fail++; $display("FAIL fill_txn%0d: got we=%b addr=%h data=%h expected 1 %h deadbeefcafef00d",
                           i, log_we[i], log_addr[i], log_data[i], 64'h9000 + 64'(8 * i));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_copy();
    test_len0();
    test_gnt_stall();
    test_abort_rd_wait();
    test_abort_last_write();
    test_rst_mid();
`ifdef DMA_FILL_EN
    test_fill();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
